// File: rtl/approx_seq_mul.sv
// Sequential shift-add multiplier producing an exact and a column-truncated product in parallel,
// with error distance and running error statistics (saturating count and maximum).
module approx_seq_mul #(
   parameter int unsigned W     = 4,
   parameter int unsigned TRUNC = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             clr_stats,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   p_exact,
   output logic [2*W-1:0]   p_apx,
   output logic [2*W-1:0]   err_dist,
   output logic [CNT_W-1:0] err_cnt,
   output logic [2*W-1:0]   err_max
);

   localparam int unsigned IW = $clog2(W);
   // Shifting by TRUNC == 2W yields an all-zero mask, so every column is dropped.
   localparam logic [2*W-1:0] APX_MASK = {(2*W){1'b1}} << TRUNC;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t         state;
   logic [W-1:0]   a_q, b_q;
   logic [IW-1:0]  iter;
   logic [2*W-1:0] acc_exact, acc_apx;

   logic [2*W-1:0] pp, acc_exact_nxt, acc_apx_nxt, diff;
   logic           last;

   // The final iteration's sum feeds the outputs on the same edge it is accumulated.
   always_comb begin
      pp            = {{W{1'b0}}, a_q} << iter;
      acc_exact_nxt = acc_exact;
      acc_apx_nxt   = acc_apx;
      if (b_q[iter]) begin
         acc_exact_nxt = acc_exact + pp;
         acc_apx_nxt   = acc_apx + (pp & APX_MASK);
      end
      diff = acc_exact_nxt - acc_apx_nxt;
      last = (iter == IW'(W - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         iter      <= '0;
         acc_exact <= '0;
         acc_apx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         p_exact   <= '0;
         p_apx     <= '0;
         err_dist  <= '0;
         err_cnt   <= '0;
         err_max   <= '0;
      end else begin
         done <= 1'b0;
         if (clr_stats) begin
            err_cnt <= '0;
            err_max <= '0;
         end
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  a_q       <= a;
                  b_q       <= b;
                  iter      <= '0;
                  acc_exact <= '0;
                  acc_apx   <= '0;
                  busy      <= 1'b1;
                  state     <= StRun;
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               acc_exact <= acc_exact_nxt;
               acc_apx   <= acc_apx_nxt;
               iter      <= iter + 1'b1;
               if (last) begin
                  state    <= StDone;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  p_exact  <= acc_exact_nxt;
                  p_apx    <= acc_apx_nxt;
                  err_dist <= diff;
                  // A coincident clear wins and this result is not counted.
                  if (!clr_stats) begin
                     if (diff != '0 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                     if (diff > err_max) err_max <= diff;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_seq_mul.sv
// Directed bench for approx_seq_mul (W=4, TRUNC=2); a second instance with CNT_W=2
// shares all inputs and is used for the counter saturation scenario.
module tb_approx_seq_mul;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       clr_stats = 1'b0;

   logic       busy, done;
   logic [7:0] p_exact, p_apx, err_dist, err_max;
   logic [7:0] err_cnt;

   logic       s_busy, s_done;
   logic [7:0] s_p_exact, s_p_apx, s_err_dist, s_err_max;
   logic [1:0] s_err_cnt;

   int checks = 0;
   int failures = 0;
   int n;
   int seen;

   always #5 clk = ~clk;

   approx_seq_mul #(.W(4), .TRUNC(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .clr_stats(clr_stats),
      .busy(busy), .done(done), .p_exact(p_exact), .p_apx(p_apx), .err_dist(err_dist),
      .err_cnt(err_cnt), .err_max(err_max)
   );

   approx_seq_mul #(.W(4), .TRUNC(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .clr_stats(clr_stats),
      .busy(s_busy), .done(s_done), .p_exact(s_p_exact), .p_apx(s_p_apx),
      .err_dist(s_err_dist), .err_cnt(s_err_cnt), .err_max(s_err_max)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Counts negedges (cycle index, E0 cycle = 1) until done is seen; bounded.
   task automatic wait_done(input int n0, output int ncyc);
      ncyc = n0;
      do begin
         @(negedge clk);
         ncyc++;
      end while (done !== 1'b1 && ncyc < 20);
   endtask

   // Issue an operation from idle at a negedge and wait for its done cycle.
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, output int ncyc);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(0, ncyc);
   endtask

   initial begin
      // Asynchronous reset between edges, before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_p_exact", p_exact, 0);
      chk("rst_p_apx", p_apx, 0);
      chk("rst_err_dist", err_dist, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_max", err_max, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("idle_no_done", seen, 0);

      // Single operation 3*3.
      run_op(4'd3, 4'd3, n);
      chk("single_latency", n, 5);
      chk("single_busy_in_done", busy, 0);
      chk("single_p_exact", p_exact, 9);
      chk("single_p_apx", p_apx, 4);
      chk("single_err_dist", err_dist, 5);
      chk("single_err_cnt", err_cnt, 1);
      chk("single_err_max", err_max, 5);
      @(negedge clk);
      chk("single_done_one_cycle", done, 0);
      chk("single_hold_p_exact", p_exact, 9);

      // Clear stats while idle.
      clr_stats = 1'b1;
      @(negedge clk);
      clr_stats = 1'b0;
      chk("clr_idle_err_cnt", err_cnt, 0);
      chk("clr_idle_err_max", err_max, 0);
      chk("clr_idle_p_exact", p_exact, 9);

      // Back-to-back: 15*15 then 4*5 with start held in the done cycle.
      run_op(4'd15, 4'd15, n);
      chk("seq1_latency", n, 5);
      chk("seq1_p_exact", p_exact, 225);
      chk("seq1_p_apx", p_apx, 220);
      chk("seq1_err_dist", err_dist, 5);
      a = 4'd4;
      b = 4'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("seq2_busy_after_accept", busy, 1);
      wait_done(0, n);
      chk("seq2_done_spacing", n, 5);
      chk("seq2_p_exact", p_exact, 20);
      chk("seq2_p_apx", p_apx, 20);
      chk("seq2_err_dist", err_dist, 0);
      chk("seq2_err_cnt", err_cnt, 1);
      chk("seq2_err_max", err_max, 5);
      @(negedge clk);

      // Start pulsed during RUN is ignored.
      a = 4'd3;
      b = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("busy_in_run", busy, 1);
      a = 4'd15;
      b = 4'd15;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, n);
      chk("ignore_latency", n, 5);
      chk("ignore_p_exact", p_exact, 9);
      chk("ignore_p_apx", p_apx, 4);
      chk("ignore_err_cnt", err_cnt, 2);
      @(negedge clk);

      // Zero operand.
      run_op(4'd0, 4'd9, n);
      chk("zero_p_exact", p_exact, 0);
      chk("zero_p_apx", p_apx, 0);
      chk("zero_err_dist", err_dist, 0);
      chk("zero_err_cnt", err_cnt, 2);
      chk("zero_err_max", err_max, 5);
      @(negedge clk);

      // clr_stats coincident with the DONE entry edge.
      a = 4'd3;
      b = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      clr_stats = 1'b1;
      @(negedge clk);
      clr_stats = 1'b0;
      chk("clr_done", done, 1);
      chk("clr_p_exact", p_exact, 9);
      chk("clr_err_dist", err_dist, 5);
      chk("clr_err_cnt", err_cnt, 0);
      chk("clr_err_max", err_max, 0);
      @(negedge clk);

      // Saturation on the CNT_W=2 instance.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         run_op(4'd3, 4'd3, n);
         chk("sat_s_err_cnt", s_err_cnt, (k < 3) ? k : 3);
         @(negedge clk);
      end
      chk("sat_main_err_cnt", err_cnt, 4);
      chk("sat_s_err_max", s_err_max, 5);

      // Reset mid-RUN aborts the operation.
      a = 4'd3;
      b = 4'd15;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_p_exact", p_exact, 0);
      chk("abort_err_cnt", err_cnt, 0);
      chk("abort_err_max", err_max, 0);
      chk("abort_s_err_cnt", s_err_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      run_op(4'd3, 4'd15, n);
      chk("post_abort_latency", n, 5);
      chk("post_abort_p_exact", p_exact, 45);
      chk("post_abort_p_apx", p_apx, 40);
      chk("post_abort_err_dist", err_dist, 5);
      chk("post_abort_err_cnt", err_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/approx_seq_mul.md
# approx_seq_mul

Parametrised sequential shift-add multiplier that computes an exact product and a column-truncated approximate product of the same operands in parallel, reports their error distance, and keeps running error statistics. It is the clocked, width-generic successor of the small combinational multiplier netlists under evaluation. It serves as the on-chip error-measurement engine for approximate-multiplier experiments: operands come in over a start/done handshake and results are held for readout.

## Interface
- `W`, 4: operand width in bits, W ≥ 2.
- `TRUNC`, 2: number of low product columns, 0..2W, forced to zero in every approximate partial product.
- `CNT_W`, 8: width of the saturating error-event counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiplication; sampled only when the block is not busy.
- `a` in W: multiplicand, unsigned; sampled with an accepted `start`.
- `b` in W: multiplier, unsigned; sampled with an accepted `start`.
- `clr_stats` in 1: synchronous clear of `err_cnt` and `err_max`.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when results are updated.
- `p_exact` out 2W: exact product a·b.
- `p_apx` out 2W: approximate product.
- `err_dist` out 2W: p_exact − p_apx; always ≥ 0.
- `err_cnt` out CNT_W: number of completed operations with err_dist ≠ 0; saturates.
- `err_max` out 2W: largest err_dist since the last reset or clear.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE / DONE:** `start`=1 latches `a`, `b` into internal registers, clears both accumulators, sets iteration counter i=0, and goes to RUN.
  - Otherwise IDLE stays in IDLE.
  - Otherwise DONE returns to IDLE.
- **RUN:** for iteration i, pp = {W'b0, a} << i.
  - If b[i]=1: acc_exact += pp, and acc_apx += pp with bits [TRUNC-1:0] forced to 0.
  - i increments each RUN cycle. After iteration i=W−1, go to DONE.
- **DONE entry edge:** the following update together.
  - `p_exact` ← acc_exact, `p_apx` ← acc_apx, `err_dist` ← acc_exact − acc_apx.
  - If the difference ≠ 0, `err_cnt` increments, holding at 2^CNT_W−1.
  - `err_max` ← max(err_max, difference).
- `start` during RUN is ignored; there is no queueing.
- `clr_stats` takes priority over a coincident stats update: both stats regs become 0 and the coinciding result is not counted. Product outputs are still updated.
- TRUNC=0 gives p_apx = p_exact. TRUNC=2W gives p_apx = 0.
- All arithmetic is unsigned and 2W bits wide; overflow cannot occur.

## Timing
- **Reset values:** busy=0, done=0, p_exact=0, p_apx=0, err_dist=0, err_cnt=0, err_max=0, FSM=IDLE.
- `rst` asserted mid-operation aborts it immediately. Outputs go to their reset values and no `done` is produced.
- **Latency:** `start` is accepted at edge E0. RUN occupies edges E1..EW. `done`=1 and results are valid in the cycle after edge EW, i.e. W+1 edges after acceptance.
- `busy`=1 from the cycle after E0 through the last RUN cycle. It is 0 in the `done` cycle.
- **Back-to-back:** `start` held high in the `done` cycle is accepted, giving a throughput of one result per W+1 cycles.
- `done` is high for exactly one cycle per accepted `start`.
- Results and stats hold their values until the next DONE entry, `clr_stats`, or `rst`.

## Test plan
All scenarios use W=4, TRUNC=2.
- **Reset:** assert `rst` asynchronously between edges -> all outputs 0 with no clock edge; release, idle 10 cycles -> `done` never pulses.
- **Single operation:** a=3, b=3, start -> `done` exactly 5 cycles after the accepting edge; p_exact=9, p_apx=4, err_dist=5, err_cnt=1, err_max=5.
- **Sequence:** a=15,b=15 then a=4,b=5 back-to-back with `start` held in the `done` cycle -> 225/220/5, then 20/20/0; err_cnt=1, err_max=5; the two `done` pulses are 5 cycles apart.
- **Busy and zero operands:** `start` pulsed during RUN with different operands -> ignored, result matches the first operands; a=0, b=9 -> all products 0, stats unchanged.
- **Stats clear:** `clr_stats` coincident with the DONE edge of a=3, b=3 -> p_exact=9, err_dist=5, err_cnt=0, err_max=0.
- **Saturation and reset abort:** CNT_W=2, four erroneous operations -> err_cnt=3 and holds; `rst` pulsed mid-RUN -> outputs 0, no `done`, and a next `start` completes normally.
